alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised execute-stage ALU with an iterative multiply/divide unit and architectural HI/LO.
//  Single-cycle logic/arith ops are registered; MULT/MULTU/DIV/DIVU run multi-cycle behind a valid/ready handshake.
//  Sits in EX; the pipeline stalls while in_ready is low.
// PARAMETERS
//  WIDTH     32  datapath width (>=8, even)
//  CTRL_W    4   op-code width
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        op request
//  in_ready   out  1        unit can accept; request accepted when in_valid & in_ready
//  ctrl       in   CTRL_W   op code (alu_pkg)
//  in1, in2   in   WIDTH    operands (in2 = shift amount [log2 WIDTH-1:0] for SLL/SRL)
//  out_valid  out  1        one-cycle pulse: out/flags valid
//  out        out  WIDTH    result
//  zero       out  1        out == 0
//  ovf        out  1        signed overflow (ADD/SUB only, else 0)
// BEHAVIOUR
//  Reset: out=0, out_valid=0, zero=1, ovf=0, HI=LO=0, state IDLE, in_ready=1. Reset mid-operation aborts it; no out_valid.
//  Ops: 0000 AND, 0001 OR (bitwise), 0010 ADD, 0110 SUB, 0111 SLT (signed), 0101 SLTU, 1100 NOR (bitwise),
//   0011 XOR, 0100 SLL, 1111 SRL, 1101 MFHI, 1110 MFLO, 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU; others -> out=0.
//  Single-cycle ops: accepted at edge N -> out_valid at N+1; in_ready stays 1, back-to-back issue allowed.
//  ADD/SUB wrap modulo 2^WIDTH; ovf = operand sign rule. SLT/SLTU out = {0..,1} or 0.
//  FSM: IDLE -> (MUL|DIV) on accept of mul/div -> BUSY for WIDTH cycles (1 bit/cycle) -> FIX (sign correction, HI/LO write) -> IDLE.
//  Mul/div latency WIDTH+2: out_valid pulses on the FIX->IDLE edge with out=LO; in_ready=0 from accept until that edge.
//  in_valid while in_ready=0 ignored (requester holds). MFHI/MFLO issued during BUSY wait; they see updated HI/LO.
//  MULT(U): {HI,LO} = full 2*WIDTH product (signed: magnitudes multiplied, negated in FIX if signs differ).
//  DIV(U): LO = quotient truncated toward zero, HI = remainder with sign of dividend.
//  Divide by zero: LO = all ones, HI = in1; no exception. Signed MIN/-1: LO = MIN, HI = 0.
//  Operands latched at accept; later changes on in1/in2 have no effect.
//  zero/ovf update only with out_valid; hold otherwise.
// STRUCTURE
//  alu_pkg: op-code localparams, FSM state enum (IDLE, BUSY, FIX), helper for signed-overflow.
//  Sub-module muldiv_iter: shift-add multiplier / restoring divider, start/done, counter, HI/LO result.
//  Top: combinational op decode, result/flag registers, handshake, HI/LO registers.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF,1 -> out 0x80000000, ovf=1, out_valid at next edge.
//  MULT 0xFFFFFFF9(-7),3 -> after 34 cycles out_valid; LO=0xFFFFFFEB, HI=0xFFFFFFFF; MFHI returns 0xFFFFFFFF.
//  DIV -7,2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5,0 -> LO=0xFFFFFFFF, HI=5.
//  DIV 0x80000000,0xFFFFFFFF -> LO=0x80000000, HI=0.
//  Issue ADD during MULT busy -> in_ready=0, not accepted; accepted the cycle after MULT out_valid.
//  Assert rst at cycle 10 of DIVU -> no out_valid, HI=LO=0, in_ready=1 immediately; AND 0xF0,0x3C afterwards -> 0x30.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, multiply/divide FSM states and flag helpers for the
// execute-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1101;
    localparam logic [3:0] OP_MFLO  = 4'b1110;
    localparam logic [3:0] OP_SRL   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signed_ovf(input logic sa, input logic sb,
                                        input logic sr, input logic sub);
        if (sub)
            return (sa != sb) && (sr != sa);
        else
            return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// with sign handling applied to the result after the last step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output md_state_t        state,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t            state_next;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     mag;
    logic [CNT_W-1:0]     cnt;
    logic                 div_mode;
    logic                 neg_main;
    logic                 neg_rem;

    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       shifted;
    logic [WIDTH-1:0]     diff;
    logic                 fits;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   prod_fix;

    always_comb begin
        a_neg   = is_signed & a[WIDTH-1];
        b_neg   = is_signed & b[WIDTH-1];
        a_abs   = a_neg ? -a : a;
        b_abs   = b_neg ? -b : b;
        add_sum = {1'b0, acc} + {1'b0, mag};
        shifted = {acc, quo[WIDTH-1]};
        fits    = shifted >= {1'b0, mag};
        // Remainder stays below the divisor, so the low bits hold the exact difference.
        diff    = shifted[WIDTH-1:0] - mag;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            quo      <= '0;
            mag      <= '0;
            cnt      <= '0;
            div_mode <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
        end else if (state == IDLE && start) begin
            acc      <= '0;
            quo      <= a_abs;
            mag      <= b_abs;
            cnt      <= '0;
            div_mode <= is_div;
            // A zero divisor yields an all-ones quotient regardless of signs.
            neg_main <= (a_neg ^ b_neg) & ~(is_div & (b == '0));
            neg_rem  <= a_neg;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (div_mode) begin
                if (fits) begin
                    acc <= diff;
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end else if (quo[0]) begin
                acc <= add_sum[WIDTH:1];
                quo <= {add_sum[0], quo[WIDTH-1:1]};
            end else begin
                acc <= {1'b0, acc[WIDTH-1:1]};
                quo <= {acc[0], quo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {acc, quo};
        prod_fix = neg_main ? -prod : prod;
        if (div_mode) begin
            lo = neg_main ? -quo : quo;
            hi = neg_rem ? -acc : acc;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: registered single-cycle ops plus a multi-cycle
// multiply/divide unit that owns the architectural HI/LO pair.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [WIDTH-1:0]  in1,
    input  logic [WIDTH-1:0]  in2,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out,
    output logic              zero,
    output logic              ovf
);

    localparam int SH_W = $clog2(WIDTH);

    // Handshake: a request transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready drops while a mul/div is in flight.
    md_state_t        md_state;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SH_W-1:0]  shamt;
    logic             alu_ovf;
    logic             accept;
    logic             md_op;
    logic             md_signed;
    logic             md_div;

    assign in_ready  = (md_state == IDLE);
    assign accept    = in_valid & in_ready;
    assign md_signed = (ctrl == CTRL_W'(OP_MULT)) || (ctrl == CTRL_W'(OP_DIV));
    assign md_div    = (ctrl == CTRL_W'(OP_DIV))  || (ctrl == CTRL_W'(OP_DIVU));
    assign md_op     = md_signed || md_div || (ctrl == CTRL_W'(OP_MULTU));

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (accept & md_op),
        .is_signed(md_signed),
        .is_div   (md_div),
        .a        (in1),
        .b        (in2),
        .state    (md_state),
        .hi       (md_hi),
        .lo       (md_lo)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        sum     = in1 + in2;
        diff    = in1 - in2;
        shamt   = in2[SH_W-1:0];
        case (ctrl)
            CTRL_W'(OP_AND):  alu_res = in1 & in2;
            CTRL_W'(OP_OR):   alu_res = in1 | in2;
            CTRL_W'(OP_XOR):  alu_res = in1 ^ in2;
            CTRL_W'(OP_NOR):  alu_res = ~(in1 | in2);
            CTRL_W'(OP_ADD): begin
                alu_res = sum;
                alu_ovf = signed_ovf(in1[WIDTH-1], in2[WIDTH-1], sum[WIDTH-1], 1'b0);
            end
            CTRL_W'(OP_SUB): begin
                alu_res = diff;
                alu_ovf = signed_ovf(in1[WIDTH-1], in2[WIDTH-1], diff[WIDTH-1], 1'b1);
            end
            CTRL_W'(OP_SLT):  alu_res = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            CTRL_W'(OP_SLTU): alu_res = {{(WIDTH-1){1'b0}}, in1 < in2};
            CTRL_W'(OP_SLL):  alu_res = in1 << shamt;
            CTRL_W'(OP_SRL):  alu_res = in1 >> shamt;
            CTRL_W'(OP_MFHI): alu_res = hi_q;
            CTRL_W'(OP_MFLO): alu_res = lo_q;
            default:          alu_res = '0;
        endcase
    end

    // The FIX cycle is the only one where HI/LO and the mul/div result land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b1;
            ovf       <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            out_valid <= 1'b0;
            if (md_state == FIX) begin
                hi_q      <= md_hi;
                lo_q      <= md_lo;
                out       <= md_lo;
                zero      <= (md_lo == '0);
                ovf       <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept && !md_op) begin
                out       <= alu_res;
                zero      <= (alu_res == '0);
                ovf       <= alu_ovf;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vector table, multi-cycle corner sequences and
// random ops checked against an arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   ctrl = 4'd0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct {
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
        logic         z;
        logic         o;
    } vec_t;
    vec_t tbl[33];

    alu_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ctrl     (ctrl),
        .in1      (in1),
        .in2      (in2),
        .out_valid(out_valid),
        .out      (out),
        .zero     (zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o);
        longint sa, sb, s;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        o = 1'b0;
        case (c)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_ADD:  begin s = sa + sb; r = a + b; o = (s > MAX_S) || (s < MIN_S); end
            OP_SUB:  begin s = sa - sb; r = a - b; o = (s > MAX_S) || (s < MIN_S); end
            OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  r = a << (b % 32);
            OP_SRL:  r = a >> (b % 32);
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            OP_MULT: begin
                s = sa * sb;
                m_hi = s[63:32]; m_lo = s[31:0]; r = m_lo;
            end
            OP_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo;
            end
            OP_DIV: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a;
                end else begin
                    s = sa / sb; m_lo = s[31:0];
                    s = sa % sb; m_hi = s[31:0];
                end
                r = m_lo;
            end
            default: begin
                if (b == 0) begin
                    m_lo = '1; m_hi = a;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
                r = m_lo;
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at a negedge, then wait (bounded) for its result pulse.
    task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_out,
                          input logic e_zero, input logic e_ovf);
        int lat;
        int busy_bad;
        logic md;
        logic [W-1:0] e;
        md = (c[3:2] == 2'b10);
        exp_q.push_back(e_out);
        check({name, "/ready_before"}, in_ready, 1);
        in_valid = 1'b1; ctrl = c; in1 = a; in2 = b;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in1 = $urandom; in2 = $urandom;
        lat = 0;
        busy_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad++;
            @(posedge clk); @(negedge clk);
            lat++;
        end
        if (md) check({name, "/ready_low_busy"}, busy_bad, 0);
        check({name, "/latency"}, lat, md ? LAT - 1 : 0);
        check({name, "/out_valid"}, out_valid, 1);
        e = exp_q.pop_front();
        check({name, "/out"}, out, e);
        check({name, "/zero"}, zero, e_zero);
        check({name, "/ovf"}, ovf, e_ovf);
        @(posedge clk); @(negedge clk);
        check({name, "/pulse_end"}, out_valid, 0);
        check({name, "/zero_hold"}, zero, e_zero);
        check({name, "/ovf_hold"}, ovf, e_ovf);
    endtask

    initial begin
        logic [3:0] c;
        logic [W-1:0] a, b, r;
        logic o;
        int n;

        tbl[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1};
        tbl[1]  = '{OP_ADD,   32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b1};
        tbl[2]  = '{OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
        tbl[3]  = '{OP_SUB,   32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[4]  = '{OP_SUB,   32'h5,        32'h5,        32'h0,        1'b1, 1'b0};
        tbl[5]  = '{OP_AND,   32'hF0,       32'h3C,       32'h30,       1'b0, 1'b0};
        tbl[6]  = '{OP_OR,    32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0};
        tbl[7]  = '{OP_XOR,   32'hFF,       32'h0F,       32'hF0,       1'b0, 1'b0};
        tbl[8]  = '{OP_NOR,   32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[9]  = '{OP_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0};
        tbl[10] = '{OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
        tbl[11] = '{OP_SLL,   32'h1,        32'h3F,       32'h80000000, 1'b0, 1'b0};
        tbl[12] = '{OP_SRL,   32'h80000000, 32'h1F,       32'h1,        1'b0, 1'b0};
        tbl[13] = '{OP_SRL,   32'h80000000, 32'h20,       32'h80000000, 1'b0, 1'b0};
        tbl[14] = '{OP_MULT,  32'hFFFFFFF9, 32'h3,        32'hFFFFFFEB, 1'b0, 1'b0};
        tbl[15] = '{OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[16] = '{OP_MFLO,  32'h0,        32'h0,        32'hFFFFFFEB, 1'b0, 1'b0};
        tbl[17] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0};
        tbl[18] = '{OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[19] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b0};
        tbl[20] = '{OP_MFHI,  32'h0,        32'h0,        32'h40000000, 1'b0, 1'b0};
        tbl[21] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 1'b0};
        tbl[22] = '{OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[23] = '{OP_DIVU,  32'h5,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[24] = '{OP_MFHI,  32'h0,        32'h0,        32'h5,        1'b0, 1'b0};
        tbl[25] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0};
        tbl[26] = '{OP_MFHI,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0};
        tbl[27] = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0};
        tbl[28] = '{OP_MFHI,  32'h0,        32'h0,        32'h1,        1'b0, 1'b0};
        tbl[29] = '{OP_DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[30] = '{OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFF9, 1'b0, 1'b0};
        tbl[31] = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       1'b0, 1'b0};
        tbl[32] = '{OP_MFHI,  32'h0,        32'h0,        32'd2,        1'b0, 1'b0};

        // Clock/reset
        repeat (3) @(negedge clk);
        check("rst/out", out, 0);
        check("rst/out_valid", out_valid, 0);
        check("rst/zero", zero, 1);
        check("rst/ovf", ovf, 0);
        check("rst/in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 33; i++)
            run_op($sformatf("vec%0d", i), tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].z, tbl[i].o);

        // ADD held during a MULT is only taken once the MULT completes.
        in_valid = 1'b1; ctrl = OP_MULT; in1 = 32'd5; in2 = 32'd6;
        @(posedge clk); @(negedge clk);
        ctrl = OP_ADD; in1 = 32'd1; in2 = 32'd2;
        n = 0;
        while (!out_valid && n < 100) begin
            check("hold/ready_low", in_ready, 0);
            @(posedge clk); @(negedge clk);
            n++;
        end
        check("hold/mult_latency", n, LAT - 1);
        check("hold/mult_out", out, 30);
        check("hold/ready_back", in_ready, 1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check("hold/add_valid", out_valid, 1);
        check("hold/add_out", out, 3);
        @(posedge clk); @(negedge clk);
        check("hold/single_accept", out_valid, 0);

        // Reset in the middle of a DIVU aborts it and clears HI/LO.
        in_valid = 1'b1; ctrl = OP_DIVU; in1 = 32'd100; in2 = 32'd7;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        check("abort/busy", in_ready, 0);
        rst = 1'b1;
        #1;
        check("abort/ready_now", in_ready, 1);
        check("abort/no_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) n++;
        end
        check("abort/no_late_valid", n, 0);
        run_op("abort/mfhi", OP_MFHI, 0, 0, 32'h0, 1'b1, 1'b0);
        run_op("abort/mflo", OP_MFLO, 0, 0, 32'h0, 1'b1, 1'b0);
        run_op("abort/and", OP_AND, 32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);

        // Random ops against the reference model; HI/LO are zero after the reset above.
        m_hi = '0;
        m_lo = '0;
        for (int i = 0; i < 200; i++) begin
            c = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            model(c, a, b, r, o);
            run_op($sformatf("rnd%0d_op%0h", i, c), c, a, b, r, (r == 0), o);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
